// File: rtl/window_feed_ctrl.sv
// Window feed controller: loads NUM_ROWS windows into row buffers, then shifts KERNEL_SIZE times per pass.
// Optional upstream starvation counter is built only when WFC_STALL_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting one window per row, ready high
// SHIFT | shift strobe for KERNEL_SIZE cycles
// DONE  | one-cycle job-complete pulse
module window_feed_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 9,
  parameter int NUM_ROWS    = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [7:0]                       cfg_passes,
  input  logic                             i_win_valid,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] i_win_data,
  output logic                             o_win_ready,
  output logic [NUM_ROWS-1:0]              o_load_en,
  output logic [DATA_WIDTH*KERNEL_SIZE-1:0] o_load_data,
  output logic                             o_shift_en,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [15:0]                      o_stall_cnt
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int SH_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);
  localparam logic [SH_W-1:0]  SHIFT_LAST = SH_W'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [ROW_W-1:0]                 r_row_idx;
  logic [SH_W-1:0]                  r_shift_cnt;
  logic [7:0]                       r_pass_cnt;
  logic [NUM_ROWS-1:0]              r_load_en;
  logic [DATA_WIDTH*KERNEL_SIZE-1:0] r_load_data;
  logic                             w_start_acc;
  logic                             w_hs;
  logic                             w_last_hs;
  logic                             w_shift_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_win_ready = 1'b0;
    o_shift_en  = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    w_start_acc = 1'b0;
    w_hs        = 1'b0;
    w_shift_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        o_win_ready = 1'b1;
        if (i_win_valid) begin
          w_hs = 1'b1;
          if (r_row_idx == LAST_ROW) w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        o_shift_en = 1'b1;
        if (r_shift_cnt == '0) begin
          w_shift_end = 1'b1;
          w_state_nxt = (r_pass_cnt <= 8'd1) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_last_hs = w_hs && (r_row_idx == LAST_ROW);

  // The last-row strobe lands in the first SHIFT cycle, so the shift counter is loaded on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_idx   <= '0;
      r_shift_cnt <= '0;
      r_pass_cnt  <= '0;
      r_load_en   <= '0;
      r_load_data <= '0;
    end else begin
      r_load_en <= '0;
      if (w_start_acc) begin
        r_pass_cnt <= (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
        r_row_idx  <= '0;
      end
      if (w_hs) begin
        r_load_data <= i_win_data;
        r_load_en   <= NUM_ROWS'(1) << r_row_idx;
        r_row_idx   <= w_last_hs ? '0 : r_row_idx + 1'b1;
      end
      if (w_last_hs)                      r_shift_cnt <= SHIFT_LAST;
      else if (o_shift_en && !w_shift_end) r_shift_cnt <= r_shift_cnt - 1'b1;
      if (w_shift_end) r_pass_cnt <= r_pass_cnt - 8'd1;
    end
  end

  assign o_load_en   = r_load_en;
  assign o_load_data = r_load_data;

`ifdef WFC_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_stall_cnt <= '0;
    else if (w_start_acc)                        r_stall_cnt <= '0;
    else if (o_win_ready && !i_win_valid && (r_stall_cnt != 16'hFFFF))
                                                 r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_window_feed_ctrl.sv
// Bench for window_feed_ctrl: builds an expected per-cycle timeline of each job from the
// load/shift/done rules and a random valid pattern, then compares every cycle.
module tb_window_feed_ctrl;
  localparam int DW   = 32;
  localparam int KS   = 9;
  localparam int NR   = 8;
  localparam int WW   = DW * KS;
  localparam int TMAX = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    cfg_passes = 8'd0;
  logic          i_win_valid = 1'b0;
  logic [WW-1:0] i_win_data = '0;
  logic          o_win_ready;
  logic [NR-1:0] o_load_en;
  logic [WW-1:0] o_load_data;
  logic          o_shift_en;
  logic          o_busy;
  logic          o_done;
  logic [15:0]   o_stall_cnt;

  window_feed_ctrl #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .NUM_ROWS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_passes(cfg_passes),
    .i_win_valid(i_win_valid), .i_win_data(i_win_data), .o_win_ready(o_win_ready),
    .o_load_en(o_load_en), .o_load_data(o_load_data), .o_shift_en(o_shift_en),
    .o_busy(o_busy), .o_done(o_done), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic          m_vld  [TMAX];
  logic [WW-1:0] m_dat  [TMAX];
  logic          m_rdy  [TMAX];
  logic          m_shf  [TMAX];
  logic          m_done [TMAX];
  logic          m_busy [TMAX];
  logic [NR-1:0] m_len  [TMAX];
  logic [WW-1:0] m_ldat [TMAX];
  int            m_stall[TMAX];
  int            m_end;

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < KS; i++) w[i*DW +: DW] = $urandom;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_stall(input int n);
`ifdef WFC_STALL_CNT_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'd0 + 16'(n * 0);
`endif
  endfunction

  // Timeline: cycle k is the interval after the k-th edge counted from the start edge (k=0).
  task automatic build(input int passes, input int mode);
    int t, rows, np, sp, st, tog;
    logic v;
    for (int i = 0; i < TMAX; i++) begin
      m_vld[i] = 1'b0; m_dat[i] = rand_word(); m_rdy[i] = 1'b0; m_shf[i] = 1'b0;
      m_done[i] = 1'b0; m_busy[i] = 1'b0; m_len[i] = '0; m_ldat[i] = '0; m_stall[i] = 0;
    end
    np = (passes == 0) ? 1 : passes;
    t = 0; st = 0; tog = 1;
    for (int p = 0; p < np; p++) begin
      rows = 0; sp = 0;
      while (rows < NR) begin
        m_rdy[t] = 1'b1;
        m_stall[t] = st;
        if (mode == 0)      v = 1'b1;
        else if (mode == 1) begin v = (tog != 0); tog = 1 - tog; end
        else                v = (sp >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        m_vld[t] = v;
        if (v) begin
          m_len[t+1][rows] = 1'b1;
          m_ldat[t+1] = m_dat[t];
          rows++;
        end else begin
          sp++; st++;
        end
        t++;
      end
      for (int s = 0; s < KS; s++) begin
        m_shf[t] = 1'b1;
        m_vld[t] = 1'($urandom_range(0, 1));
        m_stall[t] = st;
        t++;
      end
    end
    m_done[t] = 1'b1;
    m_stall[t] = st;
    m_stall[t+1] = st;
    m_end = t;
    for (int i = 0; i <= t; i++) m_busy[i] = 1'b1;
  endtask

  task automatic run_job(input int passes, input int mode);
    build(passes, mode);
    @(posedge clk); #1;
    start = 1'b1; cfg_passes = 8'(passes); i_win_valid = 1'($urandom_range(0, 1));
    for (int k = 0; k <= m_end + 1; k++) begin
      @(posedge clk); #1;
      start = (k < m_end) ? (m_shf[k] | ($urandom_range(0, 3) == 0)) : 1'b0;
      cfg_passes = 8'($urandom);
      i_win_valid = m_vld[k];
      i_win_data = m_dat[k];
      @(negedge clk);
      chk("ready",   o_win_ready, m_rdy[k]);
      chk("load_en", o_load_en,   m_len[k]);
      chk("shift",   o_shift_en,  m_shf[k]);
      chk("done",    o_done,      m_done[k]);
      chk("busy",    o_busy,      m_busy[k]);
      chk("stall",   o_stall_cnt, exp_stall(m_stall[k]));
      chk("onehot",  ($countones(o_load_en) <= 1), 1'b1);
      if (m_len[k] != '0) chk("load_data", o_load_data, m_ldat[k]);
    end
    @(posedge clk); #1;
    start = 1'b0; i_win_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", o_win_ready, 1'b0);
    chk("rst_load_en", o_load_en, '0);
    chk("rst_load_data", o_load_data, '0);
    chk("rst_shift", o_shift_en, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_stall", o_stall_cnt, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    i_win_valid = 1'b1;
    @(negedge clk);
    chk("idle_ready", o_win_ready, 1'b0);
    chk("idle_busy", o_busy, 1'b0);
    i_win_valid = 1'b0;

    run_job(1, 0);
    run_job(2, 1);
    run_job(0, 0);
    run_job(0, 2);

    // Reset mid-job after three rows have been strobed
    @(posedge clk); #1;
    start = 1'b1; cfg_passes = 8'd1; i_win_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0; i_win_valid = 1'b1; i_win_data = rand_word();
    end
    chk("pre_rst_load_en", o_load_en, 8'h04);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", o_win_ready, 1'b0);
    chk("mid_rst_load_en", o_load_en, '0);
    chk("mid_rst_load_data", o_load_data, '0);
    chk("mid_rst_shift", o_shift_en, 1'b0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_done", o_done, 1'b0);
    chk("mid_rst_stall", o_stall_cnt, 16'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_done", o_done, 1'b0);
    end
    rst_n = 1'b1;
    i_win_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", o_busy, 1'b0);
    chk("post_rst_done", o_done, 1'b0);
    run_job(1, 2);

    for (int j = 0; j < 10; j++) run_job($urandom_range(0, 3), 2);

`ifdef WFC_STALL_CNT_EN
    @(posedge clk); #1;
    start = 1'b1; cfg_passes = 8'd1; i_win_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat_stall", o_stall_cnt, 16'hFFFF);
    chk("sat_ready", o_win_ready, 1'b1);
    i_win_valid = 1'b1;
    for (int i = 0; i < 100 && !o_done; i++) @(negedge clk);
    chk("sat_done", o_done, 1'b1);
    chk("sat_stall_hold", o_stall_cnt, 16'hFFFF);
    i_win_valid = 1'b0;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
